button_events: RTL

Multi-channel successor to the single-button edge detector: synchronises, debounces and classifies `CHANNELS` independent active-high button inputs. Each channel emits one-cycle press, release and long-press pulses plus a debounced level. An optional auto-repeat mode is available. The block sits between the board push-button pins and the game logic, replacing per-button edge-detector instances.

---
 rtl/button_events.sv | 123 ++++++++++++
 1 files changed

// File: rtl/button_events.sv
// Per-channel button conditioner: 2-flop synchroniser, debounce, press/release/long-press pulses.
// Define BUTTON_EVENTS_REPEAT_EN to re-fire long_press every REPEAT_CYCLES while held.
module button_events #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] init,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`else
    logic w_unused_repeat;
    assign w_unused_repeat = |REPEAT_CYCLES;
`endif

    // Set by reset; the first running edge reports init as a press.
    logic r_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start <= 1'b1;
        end else begin
            r_start <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic          r_sync1;
        logic          r_sync2;
        logic          r_state;
        logic          r_pressed;
        logic          r_released;
        logic          r_long;
        logic [DW-1:0] r_deb_cnt;
        logic [HW-1:0] r_hold_cnt;
        logic          w_mismatch;
        logic          w_accept;
        logic          w_hold_clr;
        logic          w_hold_fire;
        logic          w_rep_fire;

        assign w_mismatch  = (r_sync2 != r_state);
        assign w_accept    = w_mismatch && (r_deb_cnt == DEB_LAST);
        // A debounce event (either direction) outranks any hold expiry on the same edge.
        assign w_hold_clr  = w_accept || !r_state || r_start;
        assign w_hold_fire = !w_hold_clr && (r_hold_cnt == HOLD_LAST);

`ifdef BUTTON_EVENTS_REPEAT_EN
        logic [RW-1:0] r_rep_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n || w_hold_clr) begin
                r_rep_cnt <= '0;
            end else if (r_hold_cnt == HOLD_MAX) begin
                r_rep_cnt <= (r_rep_cnt == REP_LAST) ? '0 : r_rep_cnt + 1'b1;
            end
        end

        assign w_rep_fire = !w_hold_clr && (r_hold_cnt == HOLD_MAX) && (r_rep_cnt == REP_LAST);
`else
        assign w_rep_fire = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync1    <= init[gi];
                r_sync2    <= init[gi];
                r_state    <= init[gi];
                r_deb_cnt  <= '0;
                r_hold_cnt <= '0;
                r_pressed  <= 1'b0;
                r_released <= 1'b0;
                r_long     <= 1'b0;
            end else begin
                r_sync1 <= button[gi];
                r_sync2 <= r_sync1;

                if (!w_mismatch || w_accept) begin
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end

                if (w_accept) begin
                    r_state <= r_sync2;
                end

                if (w_hold_clr) begin
                    r_hold_cnt <= '0;
                end else if (r_hold_cnt != HOLD_MAX) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end

                r_pressed  <= r_start ? init[gi] : (w_accept && r_sync2);
                r_released <= !r_start && w_accept && !r_sync2;
                r_long     <= w_hold_fire || w_rep_fire;
            end
        end

        assign state[gi]      = r_state;
        assign pressed[gi]    = r_pressed;
        assign released[gi]   = r_released;
        assign long_press[gi] = r_long;
    end

endmodule
